// File: rtl/hex_message_scroller_if.sv
// Board-side bundle for the HEX message engine: raw keys and message in,
// seven-segment and status LEDs out.
interface hex_message_scroller_if #(
  parameter int DIGITS  = 6,
  parameter int MSG_LEN = 8
);
  logic [1:0]           KEY;
  logic [4*MSG_LEN-1:0] msg;
  logic [MSG_LEN-1:0]   blank;
  logic [8*DIGITS-1:0]  HEX;
  logic [9:0]           LED;

  modport master (output KEY, msg, blank, input HEX, LED);
  modport slave  (input KEY, msg, blank, output HEX, LED);
endinterface

// File: rtl/hex_message_scroller.sv
// Seven-segment message engine: static, scrolling or blinking hex message,
// with debounced on/off and mode keys.
module hex_message_scroller #(
  parameter int DIGITS          = 6,
  parameter int MSG_LEN         = 8,
  parameter int STEP_CYCLES     = 12_500_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic                   clk,
  input  logic                   reset,
  hex_message_scroller_if.slave  bus
);

  localparam int OFF_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int TMR_W = $clog2(STEP_CYCLES);
  localparam int DBC_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_SCROLL = 2'd1,
    M_BLINK  = 2'd2,
    M_UNUSED = 2'd3
  } mode_t;

  function automatic logic [7:0] font(input logic [3:0] nib);
    case (nib)
      4'h0: font = 8'hC0;  4'h1: font = 8'hF9;  4'h2: font = 8'hA4;  4'h3: font = 8'hB0;
      4'h4: font = 8'h99;  4'h5: font = 8'h92;  4'h6: font = 8'h82;  4'h7: font = 8'hF8;
      4'h8: font = 8'h80;  4'h9: font = 8'h90;  4'hA: font = 8'h88;  4'hB: font = 8'h83;
      4'hC: font = 8'hC6;  4'hD: font = 8'hA1;  4'hE: font = 8'h86;  default: font = 8'h8E;
    endcase
  endfunction

  logic [1:0]       sync1, sync2, acc, press;
  logic [DBC_W-1:0] dbc [2];

  // Key conditioning: 2-FF synchroniser, debouncer, falling-edge press pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      acc    <= 2'b11;
      press  <= 2'b00;
      dbc[0] <= '0;
      dbc[1] <= '0;
    end else begin
      sync1 <= bus.KEY;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == acc[i]) begin
          dbc[i] <= '0;
        end else if (dbc[i] == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
          acc[i]   <= sync2[i];
          dbc[i]   <= '0;
          press[i] <= acc[i];
        end else begin
          dbc[i] <= dbc[i] + 1'b1;
        end
      end
    end
  end

  logic             en_q, en_d, phase_q, phase_d, clr;
  mode_t            mode_q, mode_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             counting, tick;

  assign counting = en_q && (mode_q == M_SCROLL || mode_q == M_BLINK);
  assign tick     = counting && (tmr_q == TMR_W'(STEP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      mode_q  <= M_STATIC;
      off_q   <= '0;
      phase_q <= 1'b1;
      tmr_q   <= '0;
    end else begin
      en_q    <= en_d;
      mode_q  <= mode_d;
      off_q   <= off_d;
      phase_q <= phase_d;
      tmr_q   <= tmr_d;
    end
  end

  // Key events override the step tick through the common clear
  always_comb begin
    en_d    = en_q;
    mode_d  = mode_q;
    off_d   = off_q;
    phase_d = phase_q;
    clr     = 1'b0;
    if (!counting || tick) tmr_d = '0;
    else                   tmr_d = tmr_q + 1'b1;

    if (tick) begin
      if (mode_q == M_SCROLL)
        off_d = (off_q == OFF_W'(MSG_LEN - 1)) ? '0 : off_q + 1'b1;
      else if (mode_q == M_BLINK)
        phase_d = ~phase_q;
    end

    if (press[0]) begin
      en_d = ~en_q;
      if (!en_q) clr = 1'b1;
    end
    if (press[1]) begin
      clr = 1'b1;
      case (mode_q)
        M_SCROLL: mode_d = M_BLINK;
        M_BLINK:  mode_d = M_STATIC;
        default:  mode_d = M_SCROLL;
      endcase
    end

    if (clr) begin
      off_d   = '0;
      tmr_d   = '0;
      phase_d = 1'b1;
    end
  end

  logic [8*DIGITS-1:0] hex_d, hex_q;
  logic [9:0]          led_d, led_q;
  logic [5:0]          off6;
  int                  idx;

  always_comb begin
    hex_d = '1;
    idx   = 0;
    for (int k = 0; k < DIGITS; k++) begin
      idx = (int'(off_q) + DIGITS - 1 - k) % MSG_LEN;
      if (en_q && !(mode_q == M_BLINK && !phase_q) && !bus.blank[idx])
        hex_d[8*k +: 8] = font(bus.msg[4*idx +: 4]);
    end
  end

  // Phase is reported only while enabled so the idle status reads all-dark
  assign off6  = 6'(off_q);
  assign led_d = {off6, en_q & phase_q, 2'(mode_q), en_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q <= '1;
      led_q <= '0;
    end else begin
      hex_q <= hex_d;
      led_q <= led_d;
    end
  end

  assign bus.HEX = hex_q;
  assign bus.LED = led_q;

endmodule

// File: tb/tb_hex_message_scroller.sv
// Randomised bench for hex_message_scroller: two instances (MSG_LEN 8 and 4)
// share keys and are compared each cycle against a behavioural model.
module tb_hex_message_scroller;
  localparam int STEP = 8;
  localparam int DB   = 4;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  key;
  logic [31:0] msg_a;
  logic [7:0]  blank_a;
  logic [15:0] msg_b;
  logic [3:0]  blank_b;

  always #5 clk = ~clk;

  hex_message_scroller_if #(.DIGITS(6), .MSG_LEN(8)) ifa ();
  hex_message_scroller_if #(.DIGITS(6), .MSG_LEN(4)) ifb ();

  assign ifa.KEY   = key;
  assign ifb.KEY   = key;
  assign ifa.msg   = msg_a;
  assign ifa.blank = blank_a;
  assign ifb.msg   = msg_b;
  assign ifb.blank = blank_b;

  hex_message_scroller #(.DIGITS(6), .MSG_LEN(8), .STEP_CYCLES(STEP), .DEBOUNCE_CYCLES(DB))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  hex_message_scroller #(.DIGITS(6), .MSG_LEN(4), .STEP_CYCLES(STEP), .DEBOUNCE_CYCLES(DB))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: en/mode plus a tick count since the last clear.
  logic [7:0] font_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          m_len [2] = '{8, 4};
  bit          m_en [2];
  int          m_mode [2], m_ticks [2], m_elapsed [2];
  bit          m_acc [2], m_ev [2], m_s1 [2], m_s2 [2];
  logic [DB-1:0] m_win [2];
  int          m_fill [2];
  logic [47:0] e_hex [2];
  logic [9:0]  e_led [2];

  function automatic int m_off(int i);
    return (m_mode[i] == 1) ? (m_ticks[i] % m_len[i]) : 0;
  endfunction

  function automatic bit m_phase(int i);
    return (m_mode[i] == 2) ? (m_ticks[i] % 2 == 0) : 1'b1;
  endfunction

  function automatic logic [47:0] render(int i);
    logic [47:0] h;
    int c;
    logic [3:0] nib;
    bit bl;
    h = '1;
    for (int k = 0; k < 6; k++) begin
      c   = (m_off(i) + 5 - k) % m_len[i];
      nib = (i == 0) ? msg_a[4*c +: 4] : msg_b[4*c +: 4];
      bl  = (i == 0) ? blank_a[c] : blank_b[c];
      if (m_en[i] && !(m_mode[i] == 2 && !m_phase(i)) && !bl)
        h[8*k +: 8] = font_tbl[nib];
    end
    return h;
  endfunction

  function automatic logic [9:0] leds(int i);
    return {6'(m_off(i)), m_en[i] & m_phase(i), 2'(m_mode[i]), m_en[i]};
  endfunction

  task automatic model_step();
    bit counting, clr;
    for (int i = 0; i < 2; i++) begin
      e_hex[i] = reset ? '1 : render(i);
      e_led[i] = reset ? '0 : leds(i);
    end
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_en[i] = 0; m_mode[i] = 0; m_ticks[i] = 0; m_elapsed[i] = 0;
        m_acc[i] = 1; m_ev[i] = 0; m_s1[i] = 1; m_s2[i] = 1;
        m_win[i] = '1; m_fill[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        counting = m_en[i] && m_mode[i] != 0;
        clr = 0;
        if (counting) begin
          m_elapsed[i]++;
          if (m_elapsed[i] == STEP) begin
            m_elapsed[i] = 0;
            m_ticks[i]++;
          end
        end else begin
          m_elapsed[i] = 0;
        end
        if (m_ev[0]) begin
          if (!m_en[i]) clr = 1;
          m_en[i] = !m_en[i];
        end
        if (m_ev[1]) begin
          m_mode[i] = (m_mode[i] + 1) % 3;
          clr = 1;
        end
        if (clr) begin
          m_ticks[i] = 0;
          m_elapsed[i] = 0;
        end
      end
      // A key level is accepted once the last DB synchronised samples all differ from it
      for (int j = 0; j < 2; j++) begin
        m_win[j]  = {m_win[j][DB-2:0], m_s2[j]};
        m_fill[j] = m_fill[j] + 1;
        m_ev[j]   = 0;
        if (m_fill[j] >= DB && m_win[j] == {DB{~m_acc[j]}}) begin
          m_ev[j]   = m_acc[j];
          m_acc[j]  = !m_acc[j];
          m_fill[j] = 0;
        end
        m_s2[j] = m_s1[j];
        m_s1[j] = key[j];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("hex_a", 64'(ifa.HEX), 64'(e_hex[0]));
    chk("led_a", 64'(ifa.LED), 64'(e_led[0]));
    chk("hex_b", 64'(ifb.HEX), 64'(e_hex[1]));
    chk("led_b", 64'(ifb.LED), 64'(e_led[1]));
  endtask

  task automatic press(input logic [1:0] k, input int hold);
    key = k;
    repeat (hold) step();
    key = 2'b11;
    repeat (DB + 4) step();
  endtask

  initial begin
    int r;
    key = 2'b11; msg_a = 32'h76543210; blank_a = '0; msg_b = 16'h3210; blank_b = '0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (20) step();
    chk("idle_hex", 64'(ifa.HEX), ALL1);
    chk("idle_led", 64'(ifa.LED), 64'd0);

    key[0] = 1'b0; repeat (3) step();
    key[0] = 1'b1; repeat (2) step();
    key[0] = 1'b0; repeat (3) step();
    key[0] = 1'b1; repeat (12) step();
    chk("bounce_hex", 64'(ifa.HEX), ALL1);

    key[0] = 1'b0;
    repeat (7) step();
    chk("pre_latency_hex", 64'(ifa.HEX), ALL1);
    step();
    chk("latency_left", 64'(ifa.HEX[47:40]), 64'hC0);
    chk("latency_right", 64'(ifa.HEX[7:0]), 64'h92);
    chk("latency_en", 64'(ifa.LED[0]), 64'd1);
    chk("wrap_short_msg", 64'(ifb.HEX), 64'hC0F9A4B0C0F9);
    key[0] = 1'b1;
    repeat (10) step();

    blank_a = 8'h01;
    repeat (2) step();
    chk("blank_left", 64'(ifa.HEX[47:40]), 64'hFF);
    chk("blank_next", 64'(ifa.HEX[39:32]), 64'hF9);
    blank_a = '0;

    press(2'b01, 5);
    repeat (70) step();
    press(2'b01, 6);
    repeat (20) step();
    press(2'b10, 5);
    press(2'b10, 5);
    repeat (20) step();

    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        key = 2'($urandom_range(0, 2));
        repeat ($urandom_range(1, 7)) step();
        key = 2'b11;
      end else if (r < 8) begin
        blank_a = 8'($urandom);
        blank_b = 4'($urandom);
      end else if (r < 9) begin
        msg_a = $urandom;
        msg_b = 16'($urandom);
      end
      step();
    end
    key = 2'b11; blank_a = '0; blank_b = '0;

    reset = 1'b1; step(); reset = 1'b0;
    press(2'b10, 5);
    press(2'b01, 5);
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("midstep_reset_hex", 64'(ifa.HEX), ALL1);
    chk("midstep_reset_led", 64'(ifa.LED), 64'd0);
    reset = 1'b0;
    repeat (3) step();

    key = 2'b00;
    repeat (8) step();
    chk("both_keys_mode_en", 64'(ifa.LED[2:0]), 64'd3);
    chk("both_keys_offset", 64'(ifa.LED[9:4]), 64'd0);
    key = 2'b11;
    repeat (30) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
